// File: rtl/obc_dft_pkg.sv
// Shared constants, word type and control-state encoding for the OBC DFT
// bit-serial ROM reader/accumulator.
package obc_dft_pkg;

    localparam int OBC_W    = 32;
    localparam int OBC_FRAC = 21;
    localparam int OBC_INT  = 10;
    localparam int OBC_B    = 16;

    typedef logic signed [OBC_W-1:0] obc_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/obc_lane_acc.sv
// One lane of the OBC shift-accumulator: B guard LSBs keep every halving exact,
// and the final (sign-bit) step subtracts, floors to W bits and adds the offset.
module obc_lane_acc
    import obc_dft_pkg::*;
#(
    parameter int             B      = OBC_B,
    parameter int             W      = OBC_W,
    parameter logic [W-1:0]   OFFSET = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         add,
    input  logic         last,
    input  logic [W-1:0] rom_word,
    output logic [W-1:0] y
);

    localparam int AW = W + B;

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] word_x;
    logic signed [AW:0]   sum;
    logic signed [AW-1:0] diff;
    logic        [W-1:0]  y_q, y_d;

    // The ROM word sits above the guard bits; one extra sum bit keeps the
    // add-then-halve step free of overflow.
    always_comb begin
        word_x = $signed({rom_word, {B{1'b0}}});
        sum    = $signed({acc_q[AW-1], acc_q}) + $signed({word_x[AW-1], word_x});
        diff   = acc_q - word_x;
        y_d    = W'(diff >>> B) + OFFSET;
        acc_d  = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = AW'(sum >>> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (last) begin
                y_q <= y_d;
            end
        end
    end

    assign y = y_q;

endmodule

// File: rtl/obc_dft_accumulator.sv
// Bit-serial OBC DFT reader: shifts four samples out LSB-first as ROM address
// bits and accumulates the two returned ROM lanes into one result per lane.
module obc_dft_accumulator
    import obc_dft_pkg::*;
#(
    parameter int           B       = OBC_B,
    parameter int           W       = OBC_W,
    parameter logic [W-1:0] OFFSET0 = '0,
    parameter logic [W-1:0] OFFSET1 = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           ready,
    input  logic [4*B-1:0] smp_in,
    output logic [3:0]     rom_bits,
    input  logic [W-1:0]   rom_word0,
    input  logic [W-1:0]   rom_word1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   y0,
    output logic [W-1:0]   y1
);

    localparam int            CW       = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(B - 1);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [3:0][B-1:0]  sr_q;
    logic [3:0]         rom_bits_q;
    logic               ready_q;
    logic               out_valid_q;

    logic at_msb, lane_clr, lane_add, lane_last;

    assign at_msb    = (cnt_q == LAST_CNT);
    assign lane_clr  = (state_q == IDLE) && start;
    assign lane_add  = (state_q == RUN) && !at_msb;
    assign lane_last = (state_q == RUN) && at_msb;

    // rom_bits is loaded with bit 0 on the start edge, so the ROM already sees
    // bit cnt during each RUN cycle; the shift registers stay one bit ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            rom_bits_q  <= '0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 4; i++) begin
                            sr_q[i]       <= smp_in[i*B +: B] >> 1;
                            rom_bits_q[i] <= smp_in[i*B];
                        end
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < 4; i++) begin
                        sr_q[i]       <= sr_q[i] >> 1;
                        rom_bits_q[i] <= sr_q[i][0];
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (at_msb) begin
                        rom_bits_q  <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    obc_lane_acc #(.B(B), .W(W), .OFFSET(OFFSET0)) u_lane0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (lane_clr),
        .add      (lane_add),
        .last     (lane_last),
        .rom_word (rom_word0),
        .y        (y0)
    );

    obc_lane_acc #(.B(B), .W(W), .OFFSET(OFFSET1)) u_lane1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (lane_clr),
        .add      (lane_add),
        .last     (lane_last),
        .rom_word (rom_word1),
        .y        (y1)
    );

    assign ready     = ready_q;
    assign out_valid = out_valid_q;
    assign rom_bits  = rom_bits_q;

endmodule

// File: tb/tb_obc_dft_accumulator.sv
// Scoreboard bench for obc_dft_accumulator: table-driven ROM stubs, expected
// results computed from the closed-form OBC sum and queued at start.
module tb_obc_dft_accumulator;
    import obc_dft_pkg::*;

    localparam int           B    = OBC_B;
    localparam int           W    = OBC_W;
    localparam logic [W-1:0] OFF1 = 32'h0001_2345;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           ready;
    logic [4*B-1:0] smp_in = '0;
    logic [3:0]     rom_bits;
    logic [W-1:0]   rom_word0, rom_word1;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   y0, y1;

    logic [W-1:0] rom0_tbl [16];
    logic [W-1:0] rom1_tbl [16];

    typedef struct packed {
        logic [W-1:0] e0;
        logic [W-1:0] e1;
    } want_t;
    want_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rom_word0 = rom0_tbl[rom_bits];
    assign rom_word1 = rom1_tbl[rom_bits];

    obc_dft_accumulator #(
        .B(B), .W(W), .OFFSET0(32'h0), .OFFSET1(OFF1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ready     (ready),
        .smp_in    (smp_in),
        .rom_bits  (rom_bits),
        .rom_word0 (rom_word0),
        .rom_word1 (rom_word1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, want);
        end
    endtask

    function automatic logic [3:0] addr_at(input logic [4*B-1:0] s, input int k);
        return {s[3*B+k], s[2*B+k], s[B+k], s[k]};
    endfunction

    // Closed form: y = floor((sum_{k<B-1} w_k*2^k - w_{B-1}*2^(B-1)) / 2^(B-1)) + offset
    function automatic logic [W-1:0] ref_y(input logic [4*B-1:0] s, input int lane);
        longint    t;
        longint    wl;
        obc_word_t ws;
        t = 0;
        for (int k = 0; k < B; k++) begin
            ws = (lane == 0) ? rom0_tbl[addr_at(s, k)] : rom1_tbl[addr_at(s, k)];
            wl = longint'(ws);
            if (k == B - 1) t = t - (wl <<< k);
            else            t = t + (wl <<< k);
        end
        return W'(t >>> (B - 1)) + ((lane == 0) ? 32'h0 : OFF1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [4*B-1:0] s, input int stall, input bit garble);
        int    g;
        want_t w;
        g = 0;
        while (!ready && g < 100) begin
            tick();
            g++;
        end
        check_val("ready_wait", ready, 1);
        smp_in = s;
        start  = 1'b1;
        sb_q.push_back('{e0: ref_y(s, 0), e1: ref_y(s, 1)});
        tick();
        start = 1'b0;
        if (garble) smp_in = {$urandom, $urandom};
        out_ready = (stall == 0);
        for (int k = 0; k < B; k++) begin
            @(negedge clk);
            check_val("rom_bits", rom_bits, addr_at(s, k));
            if (k == 0) begin
                check_val("run_ready", ready, 0);
                check_val("run_valid", out_valid, 0);
            end
            tick();
        end
        @(negedge clk);
        check_val("valid_latency", out_valid, 1);
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 1, 0);
            return;
        end
        w = sb_q.pop_front();
        check_val("y0", y0, w.e0);
        check_val("y1", y1, w.e1);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                tick();
                start = (i == 1);
                if (i == 1) smp_in = ~s;
                @(negedge clk);
                check_val("stall_valid", out_valid, 1);
                check_val("stall_ready", ready, 0);
                check_val("stall_y0", y0, w.e0);
                check_val("stall_y1", y1, w.e1);
            end
            tick();
            start     = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check_val("release_valid", out_valid, 1);
        end
        tick();
        @(negedge clk);
        check_val("idle_ready", ready, 1);
        check_val("idle_valid", out_valid, 0);
    endtask

    logic [4*B-1:0] s;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom0_tbl[i] = '0;
            rom1_tbl[i] = '0;
        end
        repeat (3) tick();
        @(negedge clk);
        check_val("rst_ready", ready, 1);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_rom_bits", rom_bits, 0);
        check_val("rst_y0", y0, 0);
        check_val("rst_y1", y1, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // constant lane-0 ROM, stalled consumer with an ignored start pulse
        for (int i = 0; i < 16; i++) begin
            rom0_tbl[i] = 32'h0010_0000;
            rom1_tbl[i] = $urandom;
        end
        run_txn({$urandom, $urandom}, 5, 1'b1);
        check_val("y0_const", y0, 32'hFFFF_FFE0);
        repeat (3) tick();
        @(negedge clk);
        check_val("ignored_start_ready", ready, 1);
        check_val("ignored_start_valid", out_valid, 0);

        // single set LSB walks through rom_bits
        run_txn(64'h0000_0000_0000_0001, 0, 1'b0);

        // MSB-only lane-0 term
        for (int i = 0; i < 16; i++) begin
            rom0_tbl[i] = i[0] ? 32'h0020_0000 : 32'h0;
            rom1_tbl[i] = $urandom;
        end
        s = {$urandom, $urandom};
        s[B-1:0] = 16'h8000;
        run_txn(s, 0, 1'b0);
        check_val("y0_msb", y0, 32'hFFE0_0000);

        // reset in the middle of RUN at cnt=7
        for (int i = 0; i < 16; i++) begin
            rom0_tbl[i] = $urandom;
            rom1_tbl[i] = $urandom;
        end
        s = {$urandom, $urandom};
        smp_in = s;
        start  = 1'b1;
        sb_q.push_back('{e0: ref_y(s, 0), e1: ref_y(s, 1)});
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        check_val("abort_ready", ready, 1);
        check_val("abort_valid", out_valid, 0);
        check_val("abort_rom_bits", rom_bits, 0);
        check_val("abort_y0", y0, 0);
        check_val("abort_y1", y1, 0);
        repeat (2) tick();
        check_val("abort_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        tick();
        run_txn({$urandom, $urandom}, 0, 1'b1);

        // back-to-back random transactions
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) begin
                rom0_tbl[i] = $urandom;
                rom1_tbl[i] = $urandom;
            end
            run_txn({$urandom, $urandom}, 0, 1'b1);
        end

        // extreme ROM words and samples to exercise wrap-around
        for (int i = 0; i < 16; i++) begin
            rom0_tbl[i] = i[0] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            rom1_tbl[i] = i[3] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        run_txn(64'h8000_7FFF_8000_7FFF, 0, 1'b0);
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
